// File: rtl/dog_ram_rd_arb.sv
// Purpose: shares one image-RAM read port between the filter engine (m0) and host readout (m1).
// Latency: accept -> RAM enable 1 cycle; accept -> requester return 1 + RAM latency + 1 cycles.
// Backpressure: ready withheld while MAX_OUT reads are in flight; RAM returns are never stalled.
module dog_ram_rd_arb #(
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int MAX_OUT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_rd_valid_i,
   input  logic [AW-1:0] m0_rd_addr_i,
   output logic          m0_rd_ready_o,
   output logic          m0_valid_o,
   output logic [DW-1:0] m0_data_o,
   input  logic          m1_rd_valid_i,
   input  logic [AW-1:0] m1_rd_addr_i,
   output logic          m1_rd_ready_o,
   output logic          m1_valid_o,
   output logic [DW-1:0] m1_data_o,
   output logic          ram_rd_valid_o,
   output logic [AW-1:0] ram_rd_addr_o,
   input  logic [DW-1:0] ram_data_in,
   input  logic          ram_valid_in,
   output logic          busy_o,
   output logic          err_o
);

   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUT - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

   // tag queue: one requester-id bit per outstanding read, oldest at r_rptr
   logic [MAX_OUT-1:0] r_tag;
   logic [PW-1:0]      r_wptr;
   logic [PW-1:0]      r_rptr;
   logic [CW-1:0]      r_count;
   logic               r_last_gnt;

   logic               r_ram_vld;
   logic [AW-1:0]      r_ram_addr;

   logic               r_m0_vld;
   logic               r_m1_vld;
   logic [DW-1:0]      r_m0_dat;
   logic [DW-1:0]      r_m1_dat;
   logic               r_err;

   logic               w_slot_free;
   logic               w_gnt0;
   logic               w_gnt1;
   logic               w_xfer;
   logic               w_xfer_id;
   logic [AW-1:0]      w_xfer_addr;
   logic               w_pop;
   logic               w_head;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // grant: round robin among valid requesters, only while a tag slot is free;
   // a pop in this cycle does not count as a free slot until it has been registered
   always_comb begin
      w_slot_free = !rst && (r_count < FULL_CNT);
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      if (w_slot_free) begin
         if (m0_rd_valid_i && m1_rd_valid_i) begin
            w_gnt0 = r_last_gnt;
            w_gnt1 = !r_last_gnt;
         end else begin
            w_gnt0 = m0_rd_valid_i;
            w_gnt1 = m1_rd_valid_i;
         end
      end
   end

   assign m0_rd_ready_o = w_gnt0;
   assign m1_rd_ready_o = w_gnt1;
   assign w_xfer        = w_gnt0 | w_gnt1;
   assign w_xfer_id     = w_gnt1;
   assign w_xfer_addr   = w_gnt1 ? m1_rd_addr_i : m0_rd_addr_i;
   assign w_pop         = ram_valid_in && (r_count != '0);
   assign w_head        = r_tag[r_rptr];

   // tag queue and round-robin history: push on accept, pop on RAM return
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag      <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_last_gnt <= 1'b1;
      end else begin
         if (w_xfer) begin
            r_tag[r_wptr] <= w_xfer_id;
            r_wptr        <= ptr_next(r_wptr);
            r_last_gnt    <= w_xfer_id;
         end
         if (w_pop) begin
            r_rptr <= ptr_next(r_rptr);
         end
         r_count <= r_count + CW'(w_xfer) - CW'(w_pop);
      end
   end

   // issue stage: registered copy of the accepted address toward the RAM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ram_vld  <= 1'b0;
         r_ram_addr <= '0;
      end else begin
         r_ram_vld <= w_xfer;
         if (w_xfer) begin
            r_ram_addr <= w_xfer_addr;
         end
      end
   end

   // return routing by head tag; a return with nothing outstanding is dropped and flagged
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m0_vld <= 1'b0;
         r_m1_vld <= 1'b0;
         r_m0_dat <= '0;
         r_m1_dat <= '0;
         r_err    <= 1'b0;
      end else begin
         r_m0_vld <= w_pop && !w_head;
         r_m1_vld <= w_pop && w_head;
         if (w_pop && !w_head) begin
            r_m0_dat <= ram_data_in;
         end
         if (w_pop && w_head) begin
            r_m1_dat <= ram_data_in;
         end
         if (ram_valid_in && (r_count == '0)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign ram_rd_valid_o = r_ram_vld;
   assign ram_rd_addr_o  = r_ram_addr;
   assign m0_valid_o     = r_m0_vld;
   assign m0_data_o      = r_m0_dat;
   assign m1_valid_o     = r_m1_vld;
   assign m1_data_o      = r_m1_dat;
   assign busy_o         = (r_count != '0);
   assign err_o          = r_err;

endmodule

// File: tb/tb_dog_ram_rd_arb.sv
// Bench for dog_ram_rd_arb: random requesters, behavioural RAM with run-time latency,
// a rule-level reference model for grants/issue/occupancy/error, and an in-order
// return scoreboard drained by an independent monitor.
module tb_dog_ram_rd_arb;

   localparam int AW      = 16;
   localparam int DW      = 8;
   localparam int MAX_OUT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          rv [2];
   logic [AW-1:0] ra [2];
   logic          m0_rd_ready_o, m1_rd_ready_o;
   logic          m0_valid_o, m1_valid_o;
   logic [DW-1:0] m0_data_o, m1_data_o;
   logic          ram_rd_valid_o;
   logic [AW-1:0] ram_rd_addr_o;
   logic [DW-1:0] ram_data_in;
   logic          ram_valid_in;
   logic          busy_o, err_o;

   always #5 clk = ~clk;

   dog_ram_rd_arb #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .m0_rd_valid_i  (rv[0]),
      .m0_rd_addr_i   (ra[0]),
      .m0_rd_ready_o  (m0_rd_ready_o),
      .m0_valid_o     (m0_valid_o),
      .m0_data_o      (m0_data_o),
      .m1_rd_valid_i  (rv[1]),
      .m1_rd_addr_i   (ra[1]),
      .m1_rd_ready_o  (m1_rd_ready_o),
      .m1_valid_o     (m1_valid_o),
      .m1_data_o      (m1_data_o),
      .ram_rd_valid_o (ram_rd_valid_o),
      .ram_rd_addr_o  (ram_rd_addr_o),
      .ram_data_in    (ram_data_in),
      .ram_valid_in   (ram_valid_in),
      .busy_o         (busy_o),
      .err_o          (err_o)
   );

   typedef struct {
      bit          id;
      logic [7:0]  dat;
      int          acc_cyc;
      int          lat;
   } exp_t;

   typedef struct {
      int          due;
      logic [7:0]  dat;
   } ram_t;

   exp_t          exp_q [$];
   ram_t          ram_q [$];

   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;
   int            lat    = 1;
   bit            spur   = 1'b0;

   // requester generator state
   int unsigned   left [2];
   int unsigned   pct  [2];
   bit            seqm [2];
   logic [AW-1:0] nxt  [2];
   bit            acc  [2];

   // reference model state
   int            cnt      = 0;
   int            last_gnt = 1;
   bit            exp_iv   = 1'b0;
   logic [AW-1:0] exp_ia   = '0;
   bit            err_m    = 1'b0;

   logic [7:0]    hold [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // RAM: pixel = addr[7:0], returned in order 'lat' cycles after the enable cycle
   initial begin
      ram_valid_in = 1'b0;
      ram_data_in  = '0;
      forever begin
         ram_t r;
         @(posedge clk); #1;
         if (ram_q.size() > 0 && ram_q[0].due == cyc) begin
            ram_valid_in = 1'b1;
            ram_data_in  = ram_q[0].dat;
            void'(ram_q.pop_front());
         end else if (spur) begin
            ram_valid_in = 1'b1;
            ram_data_in  = 8'hA5;
            spur         = 1'b0;
         end else begin
            ram_valid_in = 1'b0;
            ram_data_in  = 8'($urandom);
         end
         if (ram_rd_valid_o === 1'b1) begin
            r.due = cyc + lat;
            r.dat = ram_rd_addr_o[7:0];
            ram_q.push_back(r);
         end
      end
   end

   // monitor: each returned pixel must match the oldest expected read, go to its issuer, on time
   initial begin
      hold[0] = '0;
      hold[1] = '0;
      forever begin
         logic vld [2];
         logic [7:0] dat [2];
         exp_t it;
         @(negedge clk);
         vld[0] = m0_valid_o;
         vld[1] = m1_valid_o;
         dat[0] = m0_data_o;
         dat[1] = m1_data_o;
         chk("one_valid", 32'(vld[0] & vld[1]), 32'd0);
         for (int i = 0; i < 2; i++) begin
            if (vld[i] === 1'b1) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL ret_unexpected @cyc %0d: m%0d valid with data %0h, expected no return", cyc, i, dat[i]);
               end else begin
                  it = exp_q.pop_front();
                  chk("ret_id", 32'(i), 32'(it.id));
                  chk("ret_data", 32'(dat[i]), 32'(it.dat));
                  chk("ret_latency", 32'(cyc - it.acc_cyc), 32'(it.lat + 2));
                  hold[i] = it.dat;
               end
            end
         end
         chk("m0_data", 32'(m0_data_o), 32'(hold[0]));
         chk("m1_data", 32'(m1_data_o), 32'(hold[1]));
         if (rst === 1'b1) begin
            hold[0] = '0;
            hold[1] = '0;
         end
      end
   end

   // reference model: grant rules, issue stage, outstanding count, sticky error
   task automatic model_step();
      bit   can;
      bit   er [2];
      bit   pop;
      exp_t e;
      can   = (rst == 1'b0) && (cnt < MAX_OUT);
      er[0] = can && rv[0] && (!rv[1] || last_gnt == 1);
      er[1] = can && rv[1] && (!rv[0] || last_gnt == 0);
      chk("m0_rd_ready", 32'(m0_rd_ready_o), 32'(er[0]));
      chk("m1_rd_ready", 32'(m1_rd_ready_o), 32'(er[1]));
      chk("ram_rd_valid", 32'(ram_rd_valid_o), 32'(exp_iv));
      chk("ram_rd_addr", 32'(ram_rd_addr_o), 32'(exp_ia));
      chk("busy", 32'(busy_o), 32'(cnt != 0));
      chk("err", 32'(err_o), 32'(err_m));
      acc[0] = er[0];
      acc[1] = er[1];
      if (rst) begin
         cnt      = 0;
         last_gnt = 1;
         exp_q.delete();
         exp_iv   = 1'b0;
         exp_ia   = '0;
         err_m    = 1'b0;
      end else begin
         pop = ram_valid_in && (cnt > 0);
         if (ram_valid_in && cnt == 0) err_m = 1'b1;
         exp_iv = 1'b0;
         for (int id = 0; id < 2; id++) begin
            if (er[id]) begin
               exp_iv    = 1'b1;
               exp_ia    = ra[id];
               last_gnt  = id;
               e.id      = (id == 1);
               e.dat     = ra[id][7:0];
               e.acc_cyc = cyc;
               e.lat     = lat;
               exp_q.push_back(e);
            end
         end
         cnt = cnt + (exp_iv ? 1 : 0) - (pop ? 1 : 0);
      end
   endtask

   task automatic gen(input int i);
      if (!rv[i] || acc[i]) begin
         if (left[i] > 0 && $urandom_range(99) < pct[i]) begin
            rv[i]   = 1'b1;
            ra[i]   = seqm[i] ? nxt[i] : AW'($urandom);
            nxt[i]  = nxt[i] + 1'b1;
            left[i] = left[i] - 1;
         end else begin
            rv[i] = 1'b0;
         end
      end
   endtask

   task automatic setup(input int i, input int unsigned n, input int unsigned p,
                        input bit s, input logic [AW-1:0] base);
      left[i] = n;
      pct[i]  = p;
      seqm[i] = s;
      nxt[i]  = base;
   endtask

   task automatic cyc_step(input bit r);
      @(posedge clk); #1;
      rst = r;
      gen(0);
      gen(1);
      @(negedge clk); #1;
      model_step();
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rv[i]  = 1'b0;
         ra[i]  = '0;
         acc[i] = 1'b0;
         setup(i, 0, 0, 1'b0, '0);
      end

      // reset state
      repeat (3) cyc_step(1'b1);

      // single requester stream, addresses 0..15, latency 1
      lat = 1;
      setup(0, 16, 100, 1'b1, 16'h0000);
      repeat (26) cyc_step(1'b0);

      // round robin: both valid continuously from reset
      lat = 2;
      repeat (2) cyc_step(1'b1);
      setup(0, 20, 100, 1'b0, '0);
      setup(1, 20, 100, 1'b0, '0);
      repeat (55) cyc_step(1'b0);

      // full tag queue: long RAM latency throttles m0
      lat = 6;
      setup(0, 20, 100, 1'b1, 16'h0100);
      repeat (70) cyc_step(1'b0);

      // continuous push/pop with pointer wrap
      lat = 1;
      setup(0, 40, 100, 1'b1, 16'h0240);
      repeat (50) cyc_step(1'b0);

      // random mix of both requesters
      lat = 3;
      setup(0, 30, 60, 1'b0, '0);
      setup(1, 30, 70, 1'b0, '0);
      repeat (110) cyc_step(1'b0);

      // spurious return with empty queue, then traffic with the sticky flag set
      spur = 1'b1;
      repeat (5) cyc_step(1'b0);
      lat = 2;
      setup(0, 10, 80, 1'b0, '0);
      setup(1, 10, 80, 1'b0, '0);
      repeat (40) cyc_step(1'b0);

      // reset with three reads outstanding at latency 4
      lat = 4;
      setup(0, 3, 100, 1'b1, 16'h0377);
      repeat (4) cyc_step(1'b0);
      cyc_step(1'b1);
      repeat (10) cyc_step(1'b0);

      // normal operation after the mid-flight reset
      lat = 2;
      setup(0, 15, 75, 1'b0, '0);
      setup(1, 15, 75, 1'b0, '0);
      repeat (60) cyc_step(1'b0);
      repeat (15) cyc_step(1'b0);

      chk("drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
